uart_tx_serializer: RTL and testbench

//  Output stage of the UART MVM system: accepts one parallel Y result bus from the MVM core

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_serializer_if.sv | 23 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_tx_serializer.sv | 138 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default timing/framing constants, FSM state type
// and sizing helpers used by the TX serializer and the RX deserializer.
package uart_pkg;

   localparam int DEF_BITS_PER_WORD    = 8;
   localparam int DEF_CLOCKS_PER_PULSE = 2604;
   localparam int PACKET_SIZE_TX       = 13;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } uart_state_e;

   // Number of UART words carried by one parallel bus of w_bus bits.
   function automatic int n_words(input int w_bus, input int bits_per_word);
      return w_bus / bits_per_word;
   endfunction

   // Pad/stop bits that follow the data bits of one frame.
   function automatic int n_pad(input int packet_size, input int bits_per_word);
      return packet_size - bits_per_word - 1;
   endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Valid/ready result bus between the MVM core (master) and the UART TX
// serializer (slave).
interface uart_tx_serializer_if #(
   parameter int W_BUS = 16
) ();

   logic             s_valid;
   logic             s_ready;
   logic [W_BUS-1:0] s_data;

   modport master (
      output s_valid,
      output s_data,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: emits a one-cycle tick on the last cycle of every
// CLOCKS_PER_PULSE-cycle bit period while enabled; i_clear restarts the phase.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_tick
);

   localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == CNT_LAST);
   assign o_tick = i_en && w_last && !i_clear;

   // Phase counter, reloaded to zero explicitly so it never wraps by overflow.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (w_last) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART output stage: captures one parallel result over valid/ready and sends
// it as N_WORDS back-to-back UART frames, word 0 first, each word LSB-first.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int W_BUS            = 16,
   parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD,
   parameter int PACKET_SIZE      = PACKET_SIZE_TX,
   parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   uart_tx_serializer_if.slave  io_bus,
   output logic                 o_tx,
   output logic                 o_busy
);

   localparam int N_WORDS = n_words(W_BUS, BITS_PER_WORD);
   localparam int N_PAD   = n_pad(PACKET_SIZE, BITS_PER_WORD);
   localparam int N_BITS  = N_WORDS * PACKET_SIZE;
   localparam int BCW     = $clog2(N_BITS + 1);
   localparam logic [BCW-1:0] BC_LAST = BCW'(N_BITS - 1);

   if (((W_BUS % BITS_PER_WORD) != 0) || (N_PAD < 1)) begin : g_cfg_err
      $error("uart_tx_serializer: W_BUS must be a multiple of BITS_PER_WORD and PACKET_SIZE must leave >=1 pad bit");
   end

   uart_state_e       r_state;
   uart_state_e       w_state_nxt;
   logic              w_load;
   logic              w_shift;
   logic              w_done;
   logic              w_tick;
   logic              w_baud_en;
   logic [N_BITS-1:0] w_frame;
   logic [N_BITS-1:0] r_frame;
   logic [BCW-1:0]    r_bit_cnt;
   logic              r_tx;
   logic              r_busy;

   assign io_bus.s_ready = (r_state == IDLE) && !i_rst;
   assign w_baud_en      = (r_state == SEND);
   assign o_tx           = r_tx;
   assign o_busy         = r_busy;

   uart_baud_tick #(
      .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE)
   ) u_baud (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (w_load),
      .i_en    (w_baud_en),
      .o_tick  (w_tick)
   );

   // Frame image for every word: start bit at the LSB end, data LSB-first, ones as pad.
   always_comb begin
      w_frame = '1;
      for (int i = 0; i < N_WORDS; i++) begin
         w_frame[i*PACKET_SIZE +: PACKET_SIZE] =
            {{N_PAD{1'b1}}, io_bus.s_data[i*BITS_PER_WORD +: BITS_PER_WORD], 1'b0};
      end
   end

   // Next-state and datapath strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (io_bus.s_valid && io_bus.s_ready) begin
               w_state_nxt = SEND;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SEND: begin
            if (w_tick) begin
               if (r_bit_cnt == '0) begin
                  w_state_nxt = IDLE;
                  w_done      = 1'b1;
               end else begin
                  w_state_nxt = SEND;
                  w_shift     = 1'b1;
               end
            end else begin
               w_state_nxt = SEND;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Shift register refills with ones from the top so the line cannot drop after the last bit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_frame   <= '1;
         r_bit_cnt <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
      end else if (w_load) begin
         r_frame   <= {1'b1, w_frame[N_BITS-1:1]};
         r_bit_cnt <= BC_LAST;
         r_tx      <= w_frame[0];
         r_busy    <= 1'b1;
      end else if (w_shift) begin
         r_frame   <= {1'b1, r_frame[N_BITS-1:1]};
         r_bit_cnt <= r_bit_cnt - BCW'(1);
         r_tx      <= r_frame[0];
         r_busy    <= 1'b1;
      end else if (w_done) begin
         r_frame   <= '1;
         r_bit_cnt <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_frame   <= r_frame;
         r_bit_cnt <= r_bit_cnt;
         r_tx      <= r_tx;
         r_busy    <= r_busy;
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed and random checks of the UART TX serializer with a 4-cycle bit period.
module tb_uart_tx_serializer;

   localparam int W   = 16;
   localparam int CPP = 4;
   localparam int NB  = 26;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx;
   logic busy;
   int   n_chk = 0;
   int   n_err = 0;
   int   waited;
   int   lows;

   uart_tx_serializer_if #(.W_BUS(W)) bus ();

   uart_tx_serializer #(
      .W_BUS            (W),
      .BITS_PER_WORD    (8),
      .PACKET_SIZE      (13),
      .CLOCKS_PER_PULSE (CPP)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus),
      .o_tx   (tx),
      .o_busy (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected line sequence, bit i = i-th bit on the wire.
   function automatic logic [NB-1:0] frame_bits(input logic [15:0] d);
      logic [NB-1:0] f;
      for (int i = 0; i < NB; i++) begin
         int w;
         int k;
         w = i / 13;
         k = i % 13;
         if (k == 0)      f[i] = 1'b0;
         else if (k <= 8) f[i] = d[w*8 + k - 1];
         else             f[i] = 1'b1;
      end
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a result and wait for the handshake edge; returns edges waited.
   task automatic do_send(input logic [15:0] d, output int n);
      logic hs;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      n = 0;
      hs = 1'b0;
      while (!hs && n < 500) begin
         hs = bus.s_ready;
         tick();
         n++;
      end
      check_eq("handshake_seen", {31'd0, hs}, 32'd1);
      bus.s_valid = 1'b0;
   endtask

   // Check every cycle of a frame pair, optionally presenting the next result mid-frame.
   task automatic run_frame(input logic [NB-1:0] exp, input bit inj, input logic [15:0] nd);
      for (int b = 0; b < NB; b++) begin
         for (int c = 0; c < CPP; c++) begin
            check_eq($sformatf("tx_bit%0d_c%0d", b, c), {31'd0, tx}, {31'd0, exp[b]});
            check_eq("busy_in_send", {31'd0, busy}, 32'd1);
            check_eq("ready_in_send", {31'd0, bus.s_ready}, 32'd0);
            if (inj && b == 10 && c == 0) begin
               bus.s_valid = 1'b1;
               bus.s_data  = nd;
            end
            tick();
         end
      end
      check_eq("end_tx_idle", {31'd0, tx}, 32'd1);
      check_eq("end_busy", {31'd0, busy}, 32'd0);
      check_eq("end_ready", {31'd0, bus.s_ready}, 32'd1);
   endtask

   task automatic count_low(input int n, output int l);
      l = 0;
      for (int i = 0; i < n; i++) begin
         if (tx !== 1'b1) l++;
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] d;
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h1234;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("rst_tx", {31'd0, tx}, 32'd1);
         check_eq("rst_busy", {31'd0, busy}, 32'd0);
         check_eq("rst_ready", {31'd0, bus.s_ready}, 32'd0);
      end
      rst = 1'b0;
      bus.s_valid = 1'b0;
      tick();
      check_eq("post_rst_ready", {31'd0, bus.s_ready}, 32'd1);
      check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
      count_low(5, lows);
      check_eq("post_rst_no_capture", lows, 32'd0);

      do_send(16'hA53C, waited);
      run_frame(26'b11111010010101111001111000, 1'b0, 16'h0000);

      do_send(16'h5A0F, waited);
      run_frame(frame_bits(16'h5A0F), 1'b1, 16'h00FF);
      do_send(16'h00FF, waited);
      check_eq("bp_gap_edges", waited, 32'd1);
      run_frame(26'b11110000000001111111111110, 1'b0, 16'h0000);

      do_send(16'h0000, waited);
      for (int i = 0; i < 21; i++) tick();
      check_eq("mid_bit5_low", {31'd0, tx}, 32'd0);
      rst = 1'b1;
      tick();
      check_eq("abort_tx", {31'd0, tx}, 32'd1);
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      count_low(200, lows);
      check_eq("abort_no_low", lows, 32'd0);
      check_eq("abort_idle_busy", {31'd0, busy}, 32'd0);

      do_send(16'h0000, waited);
      run_frame(26'b11110000000001111000000000, 1'b0, 16'h0000);
      do_send(16'hFFFF, waited);
      run_frame(26'b11111111111101111111111110, 1'b0, 16'h0000);
      count_low(30, lows);
      check_eq("no_extra_frames", lows, 32'd0);

      for (int r = 0; r < 50; r++) begin
         d = 16'($urandom);
         for (int k = 0; k < int'($urandom_range(0, 5)); k++) tick();
         do_send(d, waited);
         run_frame(frame_bits(d), 1'b0, 16'h0000);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
